// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   state_t          : fetch FSM encoding (FETCH waits on memory, HOLD presents instr)
//   RESET_PC_DEFAULT : default byte address of the first fetch after reset
package fetch_unit_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit and the memory.
//   imem_req   : read request (fetch unit -> memory)
//   imem_addr  : word address [31:2] (fetch unit -> memory)
//   imem_ack   : read data valid this cycle (memory -> fetch unit)
//   imem_rdata : instruction word (memory -> fetch unit)
// master = fetch unit side, slave = memory side.
interface fetch_unit_if;

  logic        imem_req;
  logic [31:2] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// pc_reg: program-counter register with synchronous reset to a fixed value
// and a load enable.
//   clk    : clock
//   rst    : synchronous active-high reset, loads RESET_VAL
//   i_load : capture i_d on the next rising edge
//   i_d    : next value
//   o_q    : current value
module pc_reg #(
  parameter int                 WIDTH     = 30,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RESET_VAL;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch stage.
// Requests the word at pc, captures the returned instruction, and holds it
// for decode until downstream accepts it; acceptance loads pc from npc.
// A wait counter flags a sticky timeout if memory never answers.
//   clk         : clock
//   rst         : synchronous active-high reset
//   npc         : next word address, loaded only when an instruction is accepted
//   pc          : current word address
//   imem        : instruction-memory bus (master side)
//   instr       : held instruction for decode
//   instr_valid : instr/pc describe one fetched instruction
//   stall       : downstream not ready, keep holding
//   timeout     : sticky memory-timeout flag
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:2]         npc,
  output logic [31:2]         pc,
  fetch_unit_if.master        imem,
  output logic [31:0]         instr,
  output logic                instr_valid,
  input  logic                stall,
  output logic                timeout
);

  localparam logic [29:0] RESET_WORD = RESET_PC[31:2];

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_instr;
  logic [31:0] w_instr_next;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_next;
  logic        r_timeout;
  logic        w_timeout_next;
  logic        w_pc_load;
  logic        w_req;
  logic        w_valid;
  logic [29:0] w_pc;

  pc_reg #(
    .WIDTH     (30),
    .RESET_VAL (RESET_WORD)
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_pc_load),
    .i_d    (npc),
    .o_q    (w_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FETCH;
      r_instr   <= 32'h0000_0000;
      r_cnt     <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_instr   <= w_instr_next;
      r_cnt     <= w_cnt_next;
      r_timeout <= w_timeout_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_instr_next   = r_instr;
    w_cnt_next     = r_cnt;
    w_timeout_next = r_timeout;
    w_pc_load      = 1'b0;
    // Gated by rst so the bus is quiet and no instruction is advertised
    // during the reset cycles themselves.
    w_req          = (r_state == FETCH) && !rst;
    w_valid        = (r_state == HOLD) && !rst;

    case (r_state)
      FETCH: begin
        // stall has no effect here: there is nothing to hold yet.
        if (imem.imem_ack) begin
          // An ack on the limit cycle still wins: fetch completes, no timeout.
          w_instr_next = imem.imem_rdata;
          w_state_next = HOLD;
          w_cnt_next   = 8'd0;
        end else begin
          // Saturate at the limit; keep waiting for memory indefinitely.
          if (r_cnt != TIMEOUT) begin
            w_cnt_next = r_cnt + 8'd1;
          end
          if (w_cnt_next == TIMEOUT) begin
            w_timeout_next = 1'b1;
          end
        end
      end
      HOLD: begin
        // Any imem_ack here is spurious and deliberately ignored.
        if (!stall) begin
          w_pc_load    = 1'b1;
          w_state_next = FETCH;
          w_cnt_next   = 8'd0;
        end
      end
      default: begin
        w_state_next = FETCH;
      end
    endcase
  end

  assign pc             = w_pc;
  assign imem.imem_req  = w_req;
  assign imem.imem_addr = w_pc;
  assign instr          = r_instr;
  assign instr_valid    = w_valid;
  assign timeout        = r_timeout;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:2] npc;
  logic [31:2] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        timeout;

  fetch_unit_if imem_bus ();

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .npc         (npc),
    .pc          (pc),
    .imem        (imem_bus.master),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard pop per new instruction presented to decode.
  logic mon_prev_valid = 1'b0;
  exp_t mon_e;
  always @(posedge clk) begin
    #3;
    if (instr_valid === 1'b1 && !mon_prev_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL mon_unexpected: got instr %h pc %h expected none", instr, pc);
      end else begin
        mon_e = sb_q.pop_front();
        check("mon_pc", {2'b00, pc}, {2'b00, mon_e.pc});
        check("mon_instr", instr, mon_e.instr);
        $display("fetch: pc=%h instr=%h", pc, instr);
      end
    end
    mon_prev_valid = (instr_valid === 1'b1);
  end

  // Ack one fetch from FETCH state; stall is held high so the instruction waits in HOLD.
  task automatic fetch_ack(input logic [31:0] data, input logic [29:0] exp_pc);
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = data;
    stall               = 1'b1;
    sb_q.push_back({exp_pc, data});
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    check("hold_valid", {31'd0, instr_valid}, 32'd1);
  endtask

  // Accept the held instruction, loading pc from npc.
  task automatic accept(input logic [29:0] next_pc);
    npc   = next_pc;
    stall = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    check("accept_pc", {2'b00, pc}, {2'b00, next_pc});
    check("accept_req", {31'd0, imem_bus.imem_req}, 32'd1);
    check("accept_valid", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    rst                 = 1'b1;
    npc                 = '0;
    stall               = 1'b0;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc", {2'b00, pc}, 32'h0000_0C00);
    check("rst_instr", instr, 32'h0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);

    // Ack in the very first cycle after reset
    rst = 1'b0;
    #1;
    check("first_req", {31'd0, imem_bus.imem_req}, 32'd1);
    check("first_addr", {2'b00, imem_bus.imem_addr}, 32'h0000_0C00);
    check("first_valid", {31'd0, instr_valid}, 32'd0);
    fetch_ack(32'h2008_0005, 30'h0000_0C00);

    // HOLD with stall for 3 cycles, npc changing, spurious acks ignored
    npc = 30'h0000_0C01;
    for (int i = 0; i < 3; i++) begin
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = 32'hDEAD_BEE0 + 32'(i);
      @(negedge clk);
      check("stall_pc", {2'b00, pc}, 32'h0000_0C00);
      check("stall_instr", instr, 32'h2008_0005);
      check("stall_req", {31'd0, imem_bus.imem_req}, 32'd0);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    imem_bus.imem_ack = 1'b0;
    accept(30'h0000_0C01);

    // Fetch with stall high in FETCH (ignored), then wrap pc via npc
    fetch_ack(32'h1234_5678, 30'h0000_0C01);
    accept(30'h3FFF_FFFF);
    fetch_ack(32'hA5A5_5A5A, 30'h3FFF_FFFF);
    accept(30'h0000_0000);

    // Ack on the cycle the counter would reach the limit: no timeout
    repeat (254) @(negedge clk);
    check("lim_req", {31'd0, imem_bus.imem_req}, 32'd1);
    fetch_ack(32'hC0DE_0001, 30'h0000_0000);
    check("lim_timeout", {31'd0, timeout}, 32'd0);
    accept(30'h0000_0005);

    // Ack withheld for 255 cycles: sticky timeout, then normal completion
    repeat (254) @(negedge clk);
    check("to_before", {31'd0, timeout}, 32'd0);
    @(negedge clk);
    check("to_set", {31'd0, timeout}, 32'd1);
    repeat (3) @(negedge clk);
    check("to_wait_req", {31'd0, imem_bus.imem_req}, 32'd1);
    check("to_wait_valid", {31'd0, instr_valid}, 32'd0);
    fetch_ack(32'hBEEF_0002, 30'h0000_0005);
    check("to_sticky_hold", {31'd0, timeout}, 32'd1);
    accept(30'h0000_0006);
    check("to_sticky_fetch", {31'd0, timeout}, 32'd1);

    // Reset while holding an all-ones instruction
    fetch_ack(32'hFFFF_FFFF, 30'h0000_0006);
    rst = 1'b1;
    @(negedge clk);
    check("rsth_valid", {31'd0, instr_valid}, 32'd0);
    check("rsth_instr", instr, 32'h0);
    check("rsth_pc", {2'b00, pc}, 32'h0000_0C00);
    check("rsth_timeout", {31'd0, timeout}, 32'd0);
    check("rsth_req", {31'd0, imem_bus.imem_req}, 32'd0);

    // Reset mid-fetch with an ack during reset: discarded
    rst = 1'b0;
    @(negedge clk);
    rst                 = 1'b1;
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'h1111_1111;
    @(negedge clk);
    rst               = 1'b0;
    imem_bus.imem_ack = 1'b0;
    #1;
    check("rstf_valid", {31'd0, instr_valid}, 32'd0);
    check("rstf_instr", instr, 32'h0);
    fetch_ack(32'h7777_0000, 30'h0000_0C00);
    accept(30'h0000_0C01);

    // Drain the scoreboard (bounded)
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
